// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the two-requester divider arbiter.
package div_arbiter_pkg;

  // Default operand/result width; also the number of restoring steps.
  localparam int DIV_WIDTH = 8;

  // Arbiter sequencing states (2-bit encoding, visible on the debug port).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_arbiter_core.sv
// One restoring-division step: shift {rem,quot} left, trial-subtract the
// divisor magnitude, restore or keep, and insert the new quotient bit.
module div_arbiter_core
  import div_arbiter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0] w_shift;
  logic           w_fits;

  // The shifted remainder is WIDTH+1 bits so a divisor magnitude of
  // 2^(WIDTH-1) still compares correctly. When it fits, the true difference
  // is below the divisor, so a WIDTH-bit subtraction yields it exactly.
  always_comb begin
    w_shift = {i_rem, i_quot[WIDTH-1]};
    w_fits  = (w_shift >= {1'b0, i_divisor});
    o_rem   = w_fits ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];
    o_quot  = {i_quot[WIDTH-2:0], w_fits};
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative signed restoring divider between
// two requesters, returning tagged results on one response channel.
//
// Handshakes: every channel transfers on a cycle where valid && ready are both
// high at the rising clock edge. reqN_ready is combinational and may only be
// high in IDLE for the granted requester; request inputs are sampled only on
// the transfer cycle. rsp_valid stays high and rsp_* stay stable until the
// cycle in which rsp_ready is also high.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_quot,
  output logic [WIDTH-1:0] rsp_rem,
  output logic             rsp_neg,
  output logic             rsp_dbz,
  output logic             rsp_ovf,
  output logic [1:0]       o_dbg_state
);

  localparam int               CW           = $clog2(WIDTH);
  localparam logic [CW-1:0]    LP_LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] LP_DBZ_QUOT  = '1;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_abs_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_dbz;

  logic             w_grant;
  logic             w_xfer;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quot;

  // Tie goes to the requester not granted last; otherwise whoever is valid.
  assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  // Magnitudes as unsigned WIDTH-bit values; the most negative value maps
  // onto 2^(WIDTH-1), which is exactly representable unsigned.
  assign w_abs_a = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_abs_b = r_b[WIDTH-1] ? -r_b : r_b;

  div_arbiter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_abs_b),
    .o_rem     (w_step_rem),
    .o_quot    (w_step_quot)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state, grant/ready and response-valid decode.
  always_comb begin
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp_valid    = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req0_ready = !rst && req0_valid && !w_grant;
        req1_ready = !rst && req1_valid &&  w_grant;
        w_xfer     = req0_ready || req1_ready;
        if (w_xfer) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_next_state = (r_b == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (r_cnt == LP_LAST_STEP) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand capture, divider sequencing and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_abs_b      <= '0;
      r_rem        <= '0;
      r_quot       <= '0;
      r_cnt        <= '0;
      r_neg        <= 1'b0;
      r_dbz        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_a          <= w_grant ? req1_a : req0_a;
            r_b          <= w_grant ? req1_b : req0_b;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
          end
        end
        ST_LOAD: begin
          r_abs_b <= w_abs_b;
          r_neg   <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_cnt   <= '0;
          r_dbz   <= (r_b == '0);
          if (r_b == '0) begin
            r_quot <= LP_DBZ_QUOT;
            r_rem  <= w_abs_a;
          end else begin
            r_quot <= w_abs_a;
            r_rem  <= '0;
          end
        end
        ST_RUN: begin
          r_rem  <= w_step_rem;
          r_quot <= w_step_quot;
          r_cnt  <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Response fields: sign fix-up is skipped for divide-by-zero, and a
  // positive quotient of magnitude 2^(WIDTH-1) is flagged as overflow.
  always_comb begin
    rsp_id      = r_id;
    rsp_rem     = r_rem;
    rsp_neg     = r_neg;
    rsp_dbz     = r_dbz;
    rsp_quot    = (r_neg && !r_dbz) ? -r_quot : r_quot;
    rsp_ovf     = !r_dbz && !r_neg && r_quot[WIDTH-1];
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed cases, round-robin, backpressure,
// mid-operation reset and randomized traffic against an arithmetic model.
module tb_div_arbiter;

  localparam int W  = 8;
  localparam int EW = 2 * W + 4;

  // ---------------- clock / reset / signals ----------------
  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_a     = '0;
  logic [W-1:0] req0_b     = '0;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_a     = '0;
  logic [W-1:0] req1_b     = '0;
  logic         rsp_ready  = 1'b1;
  logic         req0_ready;
  logic         req1_ready;
  logic         rsp_valid;
  logic         rsp_id;
  logic [W-1:0] rsp_quot;
  logic [W-1:0] rsp_rem;
  logic         rsp_neg;
  logic         rsp_dbz;
  logic         rsp_ovf;
  logic [1:0]   o_dbg_state;

  always #5 clk = ~clk;

  div_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_quot    (rsp_quot),
    .rsp_rem     (rsp_rem),
    .rsp_neg     (rsp_neg),
    .rsp_dbz     (rsp_dbz),
    .rsp_ovf     (rsp_ovf),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_vec    = 0;
  int            n_err    = 0;
  int            cyc      = 0;
  int            xfer_cyc = 0;
  logic          holding  = 1'b0;
  logic [EW-1:0] hold_rsp = '0;
  logic [EW-1:0] exp_q[$];
  int            grant_log[$];
  logic [EW-1:0] obs;

  assign obs = {rsp_id, rsp_quot, rsp_rem, rsp_neg, rsp_dbz, rsp_ovf};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: signed division from plain integer arithmetic.
  // Record layout {id, quot, rem, neg, dbz, ovf}.
  function automatic logic [EW-1:0] ref_div(input logic id, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    int sa, sb, ua, ub, q, r, qs;
    logic neg, ovf;
    logic [W-1:0] qb, rb;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = (sa < 0) ? -sa : sa;
    ub  = (sb < 0) ? -sb : sb;
    neg = (sa < 0) != (sb < 0);
    if (ub == 0) begin
      qb = '1;
      rb = ua[W-1:0];
      return {id, qb, rb, neg, 1'b1, 1'b0};
    end
    q   = ua / ub;
    r   = ua % ub;
    qs  = neg ? -q : q;
    qb  = qs[W-1:0];
    rb  = r[W-1:0];
    ovf = !neg && (q > (2 ** (W - 1)) - 1);
    return {id, qb, rb, neg, 1'b0, ovf};
  endfunction

  // Monitor: records transfers, checks latency, hold stability and results.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      check("ready_in_rst", 32'(req0_ready | req1_ready), 0);
      exp_q.delete();
      holding = 1'b0;
    end else begin
      if (req0_ready || req1_ready)
        check("ready_onehot", 32'(req0_ready & req1_ready), 0);
      if (req0_valid && req0_ready) begin
        exp_q.push_back(ref_div(1'b0, req0_a, req0_b));
        grant_log.push_back(0);
        xfer_cyc = cyc;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(ref_div(1'b1, req1_a, req1_b));
        grant_log.push_back(1);
        xfer_cyc = cyc;
      end
      if (rsp_valid) begin
        check("ready_in_done", 32'(req0_ready | req1_ready), 0);
        if (!holding) begin
          holding  = 1'b1;
          hold_rsp = obs;
          if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
          else check("latency", 32'(cyc - xfer_cyc), exp_q[0][1] ? 2 : W + 2);
        end else begin
          check("rsp_stable", 32'(obs), 32'(hold_rsp));
        end
        if (rsp_ready) begin
          if (exp_q.size() != 0) check("rsp", 32'(obs), 32'(exp_q.pop_front()));
          holding = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit n, input logic [W-1:0] a, input logic [W-1:0] b);
    int  k    = 0;
    bit  done = 1'b0;
    @(posedge clk); #1;
    if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    while (!done) begin
      @(negedge clk);
      if (n ? req1_ready : req0_ready) done = 1'b1;
      else begin
        k++;
        if (k > 400) begin
          check("issue_timeout", 1, 0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    if (n) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic drain(input int n, input bit bp);
    int got = 0;
    int k   = 0;
    while (got < n && k < n * 80 + 200) begin
      @(posedge clk); #1;
      rsp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rsp_valid && rsp_ready) got++;
      k++;
    end
    if (got < n) check("drain_timeout", 32'(got), 32'(n));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
  endtask

  task automatic op(input bit n, input logic [W-1:0] a, input logic [W-1:0] b);
    fork
      issue(n, a, b);
      drain(1, 1'b0);
    join
  endtask

  task automatic rand_op(input bit n);
    logic [W-1:0] a, b;
    int mode;
    repeat ($urandom_range(0, 3)) @(posedge clk);
    mode = $urandom_range(0, 9);
    a    = W'($urandom);
    b    = W'($urandom);
    if (mode == 0) b = '0;
    if (mode == 1) begin a = 8'h80; b = 8'hFF; end
    if (mode == 2) b = 8'h80;
    if (mode == 3) a = 8'h80;
    issue(n, a, b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(o_dbg_state), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_data"}, 32'(obs), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with a requester already valid: no ready may appear during rst.
    rst = 1'b1; req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_ready", 32'(req0_ready | req1_ready), 0);

    // Round-robin from reset: both requesters continuously valid.
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) issue(1'b0, W'($urandom), W'($urandom));
      for (int i = 0; i < 4; i++) issue(1'b1, W'($urandom), W'($urandom));
      drain(8, 1'b0);
    join
    check("rr_count", 32'(grant_log.size()), 8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      check("rr_order", 32'(grant_log[i]), 32'(i % 2));

    // Directed arithmetic cases, including magnitude/sign boundaries.
    op(1'b0, 8'd100, 8'd7);
    op(1'b1, 8'h9C,  8'd7);
    op(1'b0, 8'h80,  8'd1);
    op(1'b0, 8'd5,   8'd0);
    op(1'b0, 8'h80,  8'hFF);
    op(1'b1, 8'h7F,  8'h80);
    op(1'b1, 8'h80,  8'h80);
    op(1'b0, 8'hFB,  8'd0);
    op(1'b1, 8'd0,   8'hF9);

    // Backpressure: hold rsp_ready low in DONE with another request pending.
    rsp_ready = 1'b0;
    issue(1'b1, 8'd50, 8'd6);
    req0_a = 8'd9; req0_b = 8'd2; req0_valid = 1'b1;
    begin
      int k = 0;
      @(negedge clk);
      while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
      check("bp_rsp_seen", 32'(rsp_valid), 1);
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_valid", 32'(rsp_valid), 1);
    check("bp_ready_at_handshake", 32'(req0_ready), 0);
    @(negedge clk);
    check("bp_ready_after_done", 32'(req0_ready), 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    drain(1, 1'b0);

    // Reset in the middle of RUN abandons the operation.
    issue(1'b0, 8'd77, 8'd5);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (12) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_valid), 0);
    op(1'b0, 8'd20, 8'd3);

    // Randomized concurrent traffic with random backpressure.
    fork
      for (int i = 0; i < 20; i++) rand_op(1'b0);
      for (int i = 0; i < 20; i++) rand_op(1'b1);
      drain(40, 1'b1);
    join

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
